opcode_fetch_unit: RTL and testbench
====================================

Name: opcode_fetch_unit

Overview:
- Instruction fetch sequencer for the SM83-style CPU core.
- Owns the program counter and drives memory read requests.
- Fetches an opcode, an optional CB-prefixed second opcode, and 0-2 immediate bytes.
- Drives the write strobe and data of the instruction-register bypass register directly downstream, so the decoder sees a new opcode in the same cycle it arrives from memory.

Parameters:
- PC_INIT, 16'h0000, program counter value after reset.
- ADDR_W, 16, program counter / address width.
- DATA_W, 8, memory data and opcode width.

Ports:
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_nRst  input  1  synchronous reset, active low.
- i_Enable  input  1  tick enable; when low, all registers hold.
- i_Fetch_Start  input  1  request to begin fetching the next instruction; sampled only in IDLE.
- i_Mem_Data  input  DATA_W  read data from the memory bus.
- i_Mem_Ready  input  1  read complete; i_Mem_Data is valid this cycle.
- i_Imm_Len  input  2  immediate byte count from the decoder, combinational from the bypassed opcode; sampled only on a non-CB opcode accept.
- i_Jump  input  1  load PC and abort any fetch in progress.
- i_Jump_Addr  input  ADDR_W  new PC value.
- o_Addr  output  ADDR_W  current PC, used as the memory read address.
- o_Mem_Read  output  1  read request; high in all FETCH_* states when i_Enable is high.
- o_IR_Write  output  1  combinational write strobe to the IR bypass register.
- o_IR_Data  output  DATA_W  equals i_Mem_Data; the opcode to store.
- o_CB_Prefix  output  1  registered; high while the current instruction is CB-prefixed.
- o_Imm  output  16  registered immediate; low byte first.
- o_Done  output  1  registered one-cycle pulse: instruction fully fetched.

Behaviour:
- Reset: i_nRst low at a clock edge, regardless of i_Enable. Results: state=IDLE, PC=PC_INIT, o_Imm=0, o_CB_Prefix=0, o_Done=0, latched length=0. o_Mem_Read and o_IR_Write are 0 while in IDLE.
- States: IDLE, FETCH_OP, FETCH_CB, FETCH_IMM_LO, FETCH_IMM_HI, DONE.
- IDLE:
  - i_Fetch_Start goes to FETCH_OP.
  - On that transition: o_CB_Prefix cleared, o_Imm cleared.
- FETCH_OP, cycle with i_Mem_Ready:
  - PC increments.
  - If i_Mem_Data==8'hCB: o_CB_Prefix set, next state FETCH_CB, no IR write.
  - Otherwise: o_IR_Write=1 in this cycle and i_Imm_Len is latched. A value of 3 is treated as 2.
  - Next state: length 0 goes to DONE; otherwise FETCH_IMM_LO.
- FETCH_CB, cycle with i_Mem_Ready: o_IR_Write=1, PC increments, next state DONE. CB opcodes never take immediates.
- FETCH_IMM_LO, cycle with i_Mem_Ready:
  - o_Imm[7:0] takes i_Mem_Data; o_Imm[15:8] is set to 0.
  - PC increments.
  - Latched length 2 goes to FETCH_IMM_HI; otherwise DONE.
- FETCH_IMM_HI, cycle with i_Mem_Ready: o_Imm[15:8] takes i_Mem_Data, PC increments, next state DONE.
- DONE: o_Done=1 for exactly this cycle, then IDLE. i_Fetch_Start is ignored in DONE. Minimum gap between instructions is 1 IDLE cycle.
- Wait states: while in any FETCH_* state with i_Mem_Ready low, all state holds and o_Mem_Read stays high. There is no timeout.
- Latency with zero wait states, measured from i_Fetch_Start to o_Done: 2 cycles for a 1-byte opcode, 4 cycles for a 3-byte opcode, 3 cycles for a CB opcode.
- PC wraps from 16'hFFFF to 16'h0000 with no flag.
- i_Jump (priority below reset, above everything else):
  - PC takes i_Jump_Addr, state goes to IDLE, o_CB_Prefix is cleared, and o_Imm is held.
  - If i_Jump coincides with i_Mem_Ready, the jump wins: the byte is discarded and o_IR_Write is gated to 0.
  - If i_Jump coincides with i_Fetch_Start in IDLE, the jump is taken and the start request is dropped.
- i_Enable low: all registers hold; o_Mem_Read=0 and o_IR_Write=0. Reset still applies.
- Reset during a fetch: immediate return to the reset state; no IR write in that cycle.

Decomposition:
- Shared CPU package holds:
  - state encoding enum (3 bits);
  - constant CB_PREFIX = 8'hCB;
  - constant IMM_LEN_MAX = 2.
- One natural sub-module: the PC is an instance of the existing Register block with SIZE=ADDR_W and INITIAL=PC_INIT, written on increment or jump. Everything else stays inline.

Test Plan:
- Reset, then i_Fetch_Start, with memory returning 8'h00 and ready every cycle, PC_INIT=0 -> o_IR_Write pulse carrying 8'h00 one cycle after start; o_Done the next cycle; o_Addr=16'h0001; o_Imm=0.
- Opcode 8'h21 with i_Imm_Len=2, then bytes 8'h34, 8'h12 -> o_Imm=16'h1234 at o_Done; PC advanced by 3; exactly one IR write.
- Bytes 8'hCB, 8'h37 -> no IR write on 8'hCB; IR write of 8'h37; o_CB_Prefix=1 at o_Done; PC+2.
- Wait states: i_Mem_Ready low for 3 cycles during FETCH_IMM_LO -> PC and state hold, o_Mem_Read stays high, and completion is delayed by exactly 3 cycles.
- i_Jump to 16'h0100 in the same cycle as i_Mem_Ready in FETCH_OP -> o_IR_Write=0, o_Addr=16'h0100, state IDLE, no o_Done.
- PC at 16'hFFFF fetching a 1-byte opcode -> o_Addr=16'h0000 afterwards. Also: i_Enable low mid-fetch for 2 cycles -> all outputs frozen and o_Mem_Read=0; fetch resumes correctly once i_Enable returns high.

Source files
------------

// File: rtl/opcode_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// opcode_fetch_unit_pkg: fetch-state encoding and opcode constants. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package opcode_fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_FETCH_OP     = 3'd1,
    ST_FETCH_CB     = 3'd2,
    ST_FETCH_IMM_LO = 3'd3,
    ST_FETCH_IMM_HI = 3'd4,
    ST_DONE         = 3'd5
  } fetch_state_e;

  localparam logic [7:0] CB_PREFIX   = 8'hCB;
  localparam logic [1:0] IMM_LEN_MAX = 2'd2;

  // The decoder may report 3 immediate bytes; the core never fetches more than 2.
  function automatic logic [1:0] clamp_imm_len(input logic [1:0] len);
    return (len > IMM_LEN_MAX) ? IMM_LEN_MAX : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/opcode_fetch_unit_register.sv
// ---------------------------------------------------------------------------
// opcode_fetch_unit_register: loadable register, sync active-low reset. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module opcode_fetch_unit_register #(
  parameter int              SIZE    = 16,
  parameter logic [SIZE-1:0] INITIAL = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [SIZE-1:0] d_i,
  output logic [SIZE-1:0] q_o
);

  logic [SIZE-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= INITIAL;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/opcode_fetch_unit.sv
// ---------------------------------------------------------------------------
// opcode_fetch_unit: SM83 opcode / CB / immediate fetch sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module opcode_fetch_unit
  import opcode_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
  input  logic              i_Clk,
  input  logic              i_nRst,
  input  logic              i_Enable,
  input  logic              i_Fetch_Start,
  input  logic [DATA_W-1:0] i_Mem_Data,
  input  logic              i_Mem_Ready,
  input  logic [1:0]        i_Imm_Len,
  input  logic              i_Jump,
  input  logic [ADDR_W-1:0] i_Jump_Addr,
  output logic [ADDR_W-1:0] o_Addr,
  output logic              o_Mem_Read,
  output logic              o_IR_Write,
  output logic [DATA_W-1:0] o_IR_Data,
  output logic              o_CB_Prefix,
  output logic [15:0]       o_Imm,
  output logic              o_Done
);

  fetch_state_e      state_q;
  logic [1:0]        len_q;
  logic              cb_q;
  logic [15:0]       imm_q;
  logic              done_q;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_we;

  logic              active;
  logic              in_fetch;
  logic              accept;
  logic              is_cb;
  logic [1:0]        imm_len_clamped;

  assign active          = i_Enable & i_nRst;
  assign in_fetch        = (state_q == ST_FETCH_OP)     || (state_q == ST_FETCH_CB) ||
                           (state_q == ST_FETCH_IMM_LO) || (state_q == ST_FETCH_IMM_HI);
  // A jump in the same cycle as a returning byte discards that byte.
  assign accept          = active & ~i_Jump & i_Mem_Ready & in_fetch;
  assign is_cb           = (i_Mem_Data == DATA_W'(CB_PREFIX));
  assign imm_len_clamped = clamp_imm_len(i_Imm_Len);

  assign o_Mem_Read = i_Enable & in_fetch;
  assign o_IR_Write = accept & (((state_q == ST_FETCH_OP) & ~is_cb) | (state_q == ST_FETCH_CB));
  assign o_IR_Data  = i_Mem_Data;

  assign pc_we = active & (i_Jump | accept);
  assign pc_d  = i_Jump ? i_Jump_Addr : pc_q + ADDR_W'(1);

  opcode_fetch_unit_register #(
    .SIZE    (ADDR_W),
    .INITIAL (PC_INIT)
  ) u_pc (
    .clk_i  (i_Clk),
    .rst_ni (i_nRst),
    .we_i   (pc_we),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_nRst) begin
      state_q <= ST_IDLE;
      len_q   <= 2'd0;
      cb_q    <= 1'b0;
      imm_q   <= 16'h0000;
      done_q  <= 1'b0;
    end else if (i_Enable) begin
      done_q <= 1'b0;
      if (i_Jump) begin
        state_q <= ST_IDLE;
        cb_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_Fetch_Start) begin
              state_q <= ST_FETCH_OP;
              cb_q    <= 1'b0;
              imm_q   <= 16'h0000;
            end
          end
          ST_FETCH_OP: begin
            if (i_Mem_Ready) begin
              if (is_cb) begin
                cb_q    <= 1'b1;
                state_q <= ST_FETCH_CB;
              end else begin
                len_q <= imm_len_clamped;
                if (imm_len_clamped == 2'd0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_FETCH_IMM_LO;
                end
              end
            end
          end
          ST_FETCH_CB: begin
            if (i_Mem_Ready) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_FETCH_IMM_LO: begin
            if (i_Mem_Ready) begin
              imm_q <= {8'h00, i_Mem_Data[7:0]};
              if (len_q == IMM_LEN_MAX) begin
                state_q <= ST_FETCH_IMM_HI;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_FETCH_IMM_HI: begin
            if (i_Mem_Ready) begin
              imm_q[15:8] <= i_Mem_Data[7:0];
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Addr      = pc_q;
  assign o_CB_Prefix = cb_q;
  assign o_Imm       = imm_q;
  assign o_Done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_opcode_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_opcode_fetch_unit: scoreboard bench for the opcode fetch sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_opcode_fetch_unit;

  typedef struct packed {
    logic [15:0] imm;
    logic        cb;
    logic [15:0] addr;
  } done_t;

  logic        clk = 1'b0;
  logic        i_nRst, i_Enable, i_Fetch_Start, i_Mem_Ready, i_Jump;
  logic [7:0]  i_Mem_Data;
  logic [1:0]  i_Imm_Len;
  logic [15:0] i_Jump_Addr;
  logic [15:0] o_Addr, o_Imm;
  logic        o_Mem_Read, o_IR_Write, o_CB_Prefix, o_Done;
  logic [7:0]  o_IR_Data;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_ir [$];
  done_t       exp_done [$];
  logic [7:0]  mon_ir;
  done_t       mon_done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  opcode_fetch_unit #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .PC_INIT (16'h0000)
  ) dut (
    .i_Clk         (clk),
    .i_nRst        (i_nRst),
    .i_Enable      (i_Enable),
    .i_Fetch_Start (i_Fetch_Start),
    .i_Mem_Data    (i_Mem_Data),
    .i_Mem_Ready   (i_Mem_Ready),
    .i_Imm_Len     (i_Imm_Len),
    .i_Jump        (i_Jump),
    .i_Jump_Addr   (i_Jump_Addr),
    .o_Addr        (o_Addr),
    .o_Mem_Read    (o_Mem_Read),
    .o_IR_Write    (o_IR_Write),
    .o_IR_Data     (o_IR_Data),
    .o_CB_Prefix   (o_CB_Prefix),
    .o_Imm         (o_Imm),
    .o_Done        (o_Done)
  );

  // Decoder stand-in: immediate count per opcode.
  function automatic logic [1:0] lenf(input logic [7:0] op);
    case (op)
      8'h21:   return 2'd2;
      8'h3E:   return 2'd1;
      8'hC3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Scoreboard consumers: every IR write and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (o_IR_Write === 1'b1) begin
      checks++;
      if (exp_ir.size() == 0) begin
        errors++;
        $display("FAIL ir_write_unexpected: got write of %h, none expected", o_IR_Data);
      end else begin
        mon_ir = exp_ir.pop_front();
        if (o_IR_Data !== mon_ir) begin
          errors++;
          $display("FAIL ir_data: got %h, expected %h", o_IR_Data, mon_ir);
        end
      end
    end
    if (o_Done === 1'b1) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done at addr %h, none expected", o_Addr);
      end else begin
        mon_done = exp_done.pop_front();
        if (o_Imm !== mon_done.imm || o_CB_Prefix !== mon_done.cb || o_Addr !== mon_done.addr) begin
          errors++;
          $display("FAIL done_result: got imm %h cb %b addr %h, expected imm %h cb %b addr %h",
                   o_Imm, o_CB_Prefix, o_Addr, mon_done.imm, mon_done.cb, mon_done.addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy);
    i_Mem_Ready = rdy;
    i_Mem_Data  = mem[o_Addr];
    i_Imm_Len   = lenf(i_Mem_Data);
  endtask

  task automatic push_expect(input logic [15:0] pc);
    logic [7:0]  op;
    logic [1:0]  n;
    logic [15:0] p1, p2;
    done_t       d;
    p1 = pc + 16'd1;
    p2 = pc + 16'd2;
    op = mem[pc];
    if (op == 8'hCB) begin
      exp_ir.push_back(mem[p1]);
      d.imm  = 16'h0000;
      d.cb   = 1'b1;
      d.addr = p2;
    end else begin
      n = lenf(op);
      if (n == 2'd3) n = 2'd2;
      exp_ir.push_back(op);
      d.cb   = 1'b0;
      d.imm  = (n == 2'd0) ? 16'h0000 : (n == 2'd1) ? {8'h00, mem[p1]} : {mem[p2], mem[p1]};
      d.addr = pc + 16'd1 + {14'd0, n};
    end
    exp_done.push_back(d);
  endtask

  // One full instruction fetch, optionally with wait states or enable-off cycles at fetch step stall_idx.
  task automatic run_fetch(input string name, input int exp_lat, input int stall_idx,
                           input int stall_n, input bit stall_en);
    logic [15:0] held;
    int          lat;
    int          k;
    push_expect(o_Addr);
    i_Fetch_Start = 1'b1;
    drive(1'b1);
    tick();
    i_Fetch_Start = 1'b0;
    lat = 1;
    k   = 0;
    while (o_Done !== 1'b1 && lat < 40) begin
      if (k == stall_idx) begin
        for (int s = 0; s < stall_n; s++) begin
          held = o_Addr;
          if (stall_en) begin
            i_Enable = 1'b0;
            drive(1'b1);
          end else begin
            drive(1'b0);
          end
          #1;
          checks++;
          if (o_Mem_Read !== (stall_en ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL %s stall_mem_read: got %b, expected %b", name, o_Mem_Read, !stall_en);
          end
          tick();
          checks++;
          if (o_Addr !== held) begin
            errors++;
            $display("FAIL %s stall_addr: got %h, expected %h", name, o_Addr, held);
          end
          i_Enable = 1'b1;
          lat++;
        end
      end
      drive(1'b1);
      tick();
      lat++;
      k++;
    end
    checks++;
    if (lat != exp_lat || o_Done !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (done %b), expected %0d", name, lat, o_Done, exp_lat);
    end
    drive(1'b0);
    tick();
    checks++;
    if (o_Done !== 1'b0 || o_Mem_Read !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done %b mem_read %b, expected 0 0", name, o_Done, o_Mem_Read);
    end
  endtask

  task automatic jump_to(input logic [15:0] a);
    i_Jump      = 1'b1;
    i_Jump_Addr = a;
    drive(1'b0);
    tick();
    i_Jump = 1'b0;
  endtask

  task automatic test_reset();
    i_nRst        = 1'b0;
    i_Enable      = 1'b0;
    i_Fetch_Start = 1'b1;
    drive(1'b1);
    tick();
    tick();
    checks++;
    if (o_Addr !== 16'h0000 || o_Imm !== 16'h0000 || o_CB_Prefix !== 1'b0 || o_Done !== 1'b0 ||
        o_Mem_Read !== 1'b0 || o_IR_Write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got addr %h imm %h cb %b done %b rd %b irw %b, expected all zero",
               o_Addr, o_Imm, o_CB_Prefix, o_Done, o_Mem_Read, o_IR_Write);
    end
    i_nRst        = 1'b1;
    i_Enable      = 1'b1;
    i_Fetch_Start = 1'b0;
    drive(1'b0);
    tick();
  endtask

  task automatic test_opcodes();
    run_fetch("single_byte", 2, -1, 0, 1'b0);
    checks++;
    if (o_Addr !== 16'h0001 || o_Imm !== 16'h0000) begin
      errors++;
      $display("FAIL single_byte_state: got addr %h imm %h, expected 0001 0000", o_Addr, o_Imm);
    end
    run_fetch("imm16", 4, -1, 0, 1'b0);
    run_fetch("cb", 3, -1, 0, 1'b0);
    run_fetch("imm_len3", 4, -1, 0, 1'b0);
    run_fetch("imm8", 3, -1, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_fetch("wait_states", 7, 1, 3, 1'b0);
    checks++;
    if (o_Imm !== 16'h0C0D || o_Addr !== 16'h000E) begin
      errors++;
      $display("FAIL wait_result: got imm %h addr %h, expected 0c0d 000e", o_Imm, o_Addr);
    end
  endtask

  task automatic test_jump();
    jump_to(16'h0500);
    run_fetch("jump_setup", 4, -1, 0, 1'b0);
    jump_to(16'h0600);
    checks++;
    if (o_Addr !== 16'h0600 || o_Imm !== 16'hBEEF) begin
      errors++;
      $display("FAIL jump_idle: got addr %h imm %h, expected 0600 beef", o_Addr, o_Imm);
    end
    // Jump racing a ready opcode byte
    i_Fetch_Start = 1'b1;
    drive(1'b0);
    tick();
    i_Fetch_Start = 1'b0;
    i_Jump        = 1'b1;
    i_Jump_Addr   = 16'h0100;
    drive(1'b1);
    #1;
    checks++;
    if (o_IR_Write !== 1'b0) begin
      errors++;
      $display("FAIL jump_ir_gate: got ir_write %b, expected 0", o_IR_Write);
    end
    tick();
    i_Jump = 1'b0;
    checks++;
    if (o_Addr !== 16'h0100 || o_Done !== 1'b0 || o_Mem_Read !== 1'b0) begin
      errors++;
      $display("FAIL jump_fetch_op: got addr %h done %b rd %b, expected 0100 0 0", o_Addr, o_Done, o_Mem_Read);
    end
    drive(1'b0);
    tick();
    checks++;
    if (o_Done !== 1'b0) begin
      errors++;
      $display("FAIL jump_no_done: got done %b, expected 0", o_Done);
    end
    // Jump while waiting for the CB second byte
    i_Fetch_Start = 1'b1;
    drive(1'b0);
    tick();
    i_Fetch_Start = 1'b0;
    drive(1'b1);
    tick();
    checks++;
    if (o_CB_Prefix !== 1'b1 || o_Addr !== 16'h0101) begin
      errors++;
      $display("FAIL jump_cb_setup: got cb %b addr %h, expected 1 0101", o_CB_Prefix, o_Addr);
    end
    i_Jump      = 1'b1;
    i_Jump_Addr = 16'h0200;
    drive(1'b1);
    tick();
    i_Jump = 1'b0;
    checks++;
    if (o_CB_Prefix !== 1'b0 || o_Addr !== 16'h0200 || o_Mem_Read !== 1'b0) begin
      errors++;
      $display("FAIL jump_cb: got cb %b addr %h rd %b, expected 0 0200 0", o_CB_Prefix, o_Addr, o_Mem_Read);
    end
    // Jump and start together: start is dropped
    i_Fetch_Start = 1'b1;
    i_Jump        = 1'b1;
    i_Jump_Addr   = 16'h0300;
    drive(1'b0);
    tick();
    i_Fetch_Start = 1'b0;
    i_Jump        = 1'b0;
    drive(1'b0);
    tick();
    checks++;
    if (o_Addr !== 16'h0300 || o_Mem_Read !== 1'b0 || o_Done !== 1'b0) begin
      errors++;
      $display("FAIL jump_start: got addr %h rd %b done %b, expected 0300 0 0", o_Addr, o_Mem_Read, o_Done);
    end
  endtask

  task automatic test_wrap();
    jump_to(16'hFFFF);
    run_fetch("wrap", 2, -1, 0, 1'b0);
    checks++;
    if (o_Addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr: got %h, expected 0000", o_Addr);
    end
  endtask

  task automatic test_enable();
    jump_to(16'h0400);
    run_fetch("enable", 6, 0, 2, 1'b1);
    checks++;
    if (o_Imm !== 16'hABCD || o_Addr !== 16'h0403) begin
      errors++;
      $display("FAIL enable_result: got imm %h addr %h, expected abcd 0403", o_Imm, o_Addr);
    end
  endtask

  task automatic test_reset_midfetch();
    jump_to(16'h0700);
    i_Fetch_Start = 1'b1;
    drive(1'b0);
    tick();
    i_Fetch_Start = 1'b0;
    i_nRst        = 1'b0;
    drive(1'b1);
    tick();
    i_nRst = 1'b1;
    drive(1'b0);
    checks++;
    if (o_Addr !== 16'h0000 || o_Mem_Read !== 1'b0 || o_Done !== 1'b0 || o_CB_Prefix !== 1'b0) begin
      errors++;
      $display("FAIL reset_midfetch: got addr %h rd %b done %b cb %b, expected 0000 0 0 0",
               o_Addr, o_Mem_Read, o_Done, o_CB_Prefix);
    end
    tick();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0001] = 8'h21; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;
    mem[16'h0004] = 8'hCB; mem[16'h0005] = 8'h37;
    mem[16'h0006] = 8'hC3; mem[16'h0007] = 8'h78; mem[16'h0008] = 8'h56;
    mem[16'h0009] = 8'h3E; mem[16'h000A] = 8'hAA;
    mem[16'h000B] = 8'h21; mem[16'h000C] = 8'h0D; mem[16'h000D] = 8'h0C;
    mem[16'h0500] = 8'h21; mem[16'h0501] = 8'hEF; mem[16'h0502] = 8'hBE;
    mem[16'h0100] = 8'hCB; mem[16'h0101] = 8'h37;
    mem[16'h0400] = 8'h21; mem[16'h0401] = 8'hCD; mem[16'h0402] = 8'hAB;
    i_Jump      = 1'b0;
    i_Jump_Addr = 16'h0000;
    i_Mem_Data  = 8'h00;
    i_Mem_Ready = 1'b0;
    i_Imm_Len   = 2'd0;

    test_reset();
    test_opcodes();
    test_wait_states();
    test_jump();
    test_wrap();
    test_enable();
    test_reset_midfetch();

    checks++;
    if (exp_ir.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d ir and %0d done left, expected 0 0",
               exp_ir.size(), exp_done.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
